vdc_meter_real: RTL and testbench

//  Measures a PWC real DC voltage, e.g. the output of a DC source stub, on a digital clock.

---
 rtl/vdc_meter_real_if.sv | 21 ++
 rtl/vdc_meter_real.sv | 125 ++++++++++++
 tb/tb_vdc_meter_real.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vdc_meter_real_if.sv
// DC meter bus: stimulus side drives vin/start,
// meter side returns status and results.
interface vdc_meter_real_if;
  real  vin;
  logic start;
  logic busy;
  logic valid;
  real  vmean;
  real  vripple;
  logic pass;

  modport master (
    output vin, start,
    input  busy, valid, vmean, vripple, pass
  );

  modport slave (
    input  vin, start,
    output busy, valid, vmean, vripple, pass
  );
endinterface

// File: rtl/vdc_meter_real.sv
// Real-valued DC meter: settle, average N_AVG samples,
// report mean, ripple and pass against TARGET +/- TOL.
module vdc_meter_real #(
  parameter int unsigned N_SETTLE = 4,
  parameter int unsigned N_AVG    = 16,
  parameter real         TARGET   = 0.3,
  parameter real         TOL      = 0.01
) (
  input logic             clk,
  input logic             rst,
  vdc_meter_real_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  int unsigned cnt;
  real         acc;
  real         vmin;
  real         vmax;
  logic        fresh;
  real         mean_nx;
  real         dev;
  logic        last_settle;
  logic        last_sample;
  logic        go;

  assign last_settle = (cnt + 1 == N_SETTLE);
  assign last_sample = (cnt + 1 == N_AVG);
  assign go = bus.start &&
              (state == IDLE || state == DONE);
  assign bus.busy = (state == SETTLE) ||
                    (state == MEASURE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start)
          state_nx = (N_SETTLE == 0) ? MEASURE : SETTLE;
      end
      SETTLE: begin
        if (last_settle) state_nx = MEASURE;
      end
      MEASURE: begin
        if (last_sample) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // result arithmetic on the finished window
  always_comb begin
    mean_nx = acc / real'(N_AVG);
    dev     = mean_nx - TARGET;
    if (dev < 0.0) dev = -dev;
  end

  // counters, accumulation and result publishing
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 0;
      acc         <= 0.0;
      vmin        <= 0.0;
      vmax        <= 0.0;
      fresh       <= 1'b0;
      bus.valid   <= 1'b0;
      bus.vmean   <= 0.0;
      bus.vripple <= 0.0;
      bus.pass    <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      // publish one cycle after the last sample lands
      if (fresh) begin
        bus.valid   <= 1'b1;
        bus.vmean   <= mean_nx;
        bus.vripple <= vmax - vmin;
        bus.pass    <= (dev <= TOL);
        fresh       <= 1'b0;
      end
      unique case (state)
        IDLE, DONE: begin
          if (go) begin
            cnt <= 0;
            acc <= 0.0;
          end
        end
        SETTLE: begin
          cnt <= last_settle ? 0 : cnt + 1;
        end
        MEASURE: begin
          acc <= acc + bus.vin;
          if (cnt == 0) begin
            vmin <= bus.vin;
            vmax <= bus.vin;
          end else begin
            if (bus.vin < vmin) vmin <= bus.vin;
            if (bus.vin > vmax) vmax <= bus.vin;
          end
          if (last_sample) begin
            cnt   <= 0;
            fresh <= 1'b1;
          end else begin
            cnt <= cnt + 1;
          end
        end
        default: cnt <= 0;
      endcase
    end
  end

endmodule

// File: tb/tb_vdc_meter_real.sv
// Randomized bench for vdc_meter_real against a
// window-sampling reference model.
module tb_vdc_meter_real;

  localparam real TGT = 0.3;
  localparam real TL  = 0.01;

  logic clk = 1'b0;
  logic rst;
  real  vin;
  logic st_a;
  logic st_b;
  int   checks = 0;
  int   errors = 0;

  vdc_meter_real_if bus ();
  vdc_meter_real_if bus6 ();

  assign bus.vin    = vin;
  assign bus.start  = st_a;
  assign bus6.vin   = vin;
  assign bus6.start = st_b;

  vdc_meter_real dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  vdc_meter_real #(
    .N_SETTLE(0),
    .N_AVG(1)
  ) dut6 (
    .clk(clk),
    .rst(rst),
    .bus(bus6.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input real got,
                       input real exp);
    checks++;
    if (got - exp > 1e-9 || exp - got > 1e-9) begin
      errors++;
      $display("FAIL %s: got %f expected %f",
               tag, got, exp);
    end
  endtask

  function automatic real vgen(input int mode,
                               input int i,
                               input int s,
                               input real base);
    int r;
    case (mode)
      1: return (i % 2 == 1) ? base - 0.01 : base + 0.01;
      2: return (i <= s) ? 1.0 : base;
      3: begin
        r = int'($urandom_range(0, 4000)) - 2000;
        return base + real'(r) * 1e-5;
      end
      default: return base;
    endcase
  endfunction

  // One measurement: start pulse, drive a vin pattern,
  // and predict results from the samples in the window.
  task automatic run(input string tag, input int mode,
                     input real base, input bit sel,
                     input bit repulse);
    int  s;
    int  a;
    int  vat;
    int  vcnt;
    real q[$];
    real sum;
    real mn;
    real mx;
    real mean;
    real dv;
    real g_mean;
    real g_rip;
    real g_pass;
    logic v;
    s = sel ? 0 : 4;
    a = sel ? 1 : 16;
    vat = -1;
    vcnt = 0;
    g_mean = 0.0;
    g_rip = 0.0;
    g_pass = 0.0;
    @(negedge clk);
    vin = vgen(mode, 0, s, base);
    if (sel) st_b = 1'b1;
    else     st_a = 1'b1;
    for (int i = 1; i <= s + a + 5; i++) begin
      @(negedge clk);
      st_a = 1'b0;
      st_b = 1'b0;
      if (repulse && (i == 3 || i == 10)) st_a = 1'b1;
      if (i == 1)
        check({tag, "_busy"},
              real'(sel ? bus6.busy : bus.busy), 1.0);
      v = sel ? bus6.valid : bus.valid;
      if (v) begin
        vcnt++;
        if (vat < 0) begin
          vat = i;
          g_mean = sel ? bus6.vmean : bus.vmean;
          g_rip  = sel ? bus6.vripple : bus.vripple;
          g_pass = real'(sel ? bus6.pass : bus.pass);
        end
      end
      vin = vgen(mode, i, s, base);
      if (i >= s + 1 && i <= s + a) q.push_back(vin);
    end
    sum = 0.0;
    mn = q[0];
    mx = q[0];
    foreach (q[j]) begin
      sum += q[j];
      if (q[j] < mn) mn = q[j];
      if (q[j] > mx) mx = q[j];
    end
    mean = sum / real'(a);
    dv = (mean > TGT) ? mean - TGT : TGT - mean;
    check({tag, "_lat"}, real'(vat), real'(s + a + 2));
    check({tag, "_npulse"}, real'(vcnt), 1.0);
    check({tag, "_mean"}, g_mean, mean);
    check({tag, "_ripple"}, g_rip, mx - mn);
    if (dv - TL > 1e-9 || TL - dv > 1e-9)
      check({tag, "_pass"}, g_pass, (dv <= TL) ? 1.0 : 0.0);
    check({tag, "_hold"},
          sel ? bus6.vmean : bus.vmean, mean);
  endtask

  initial begin
    int vcnt;
    rst  = 1'b1;
    st_a = 1'b0;
    st_b = 1'b0;
    vin  = 0.0;
    repeat (2) @(negedge clk);
    check("rst_busy", real'(bus.busy), 0.0);
    check("rst_valid", real'(bus.valid), 0.0);
    check("rst_pass", real'(bus.pass), 0.0);
    check("rst_mean", bus.vmean, 0.0);
    check("rst_ripple", bus.vripple, 0.0);
    check("rst6_busy", real'(bus6.busy), 0.0);
    rst = 1'b0;

    run("t1", 0, 0.3, 1'b0, 1'b0);
    run("t2a", 0, 0.32, 1'b0, 1'b0);
    run("t2b", 0, 0.305, 1'b0, 1'b0);
    run("t3", 1, 0.3, 1'b0, 1'b0);
    run("t4", 2, 0.3, 1'b0, 1'b0);
    run("t5", 0, 0.295, 1'b0, 1'b1);
    run("t6", 0, 0.42, 1'b1, 1'b0);
    run("t6b", 0, 0.3, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      run("rnd", 3, 0.3, 1'b0, 1'b0);
      run("rnd6", 3, 0.3, 1'b1, 1'b0);
    end
    run("rnd_alt", 1, 0.29 + real'($urandom_range(0, 20)) * 1e-3,
        1'b0, 1'b0);

    // reset in the middle of a measurement
    @(negedge clk);
    st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", real'(bus.busy), 1.0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", real'(bus.busy), 0.0);
    check("abort_valid", real'(bus.valid), 0.0);
    check("abort_mean", bus.vmean, 0.0);
    check("abort_ripple", bus.vripple, 0.0);
    check("abort_pass", real'(bus.pass), 0.0);
    rst = 1'b0;
    vcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.valid) vcnt++;
    end
    check("abort_novalid", real'(vcnt), 0.0);

    // start and reset together: reset wins
    st_a = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_wins_busy", real'(bus.busy), 0.0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
